// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit: radix-2 shift-add multiply and
// restoring divide over 32 iterations, results held in Hi/Lo.
module mult_div_unit (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic        Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] Hi,
   output logic [31:0] Lo,
   output logic        Busy,
   output logic        Done,
   output logic        DivZero
);

   // state | meaning
   // IDLE  | waiting for Start; Done may be high for the cycle after a result
   // MULT  | shift-add iteration, acc = {partial product, multiplier}
   // DIV   | restoring iteration, acc = {remainder, quotient}
   // FIN   | sign correction and Hi/Lo write on exit (skipped for divide-by-zero)
   typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;

   state_t      state_q, state_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] dvs_q, dvs_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        op_q, op_d;
   logic        neg_q, neg_d;
   logic        rneg_q, rneg_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        dz_q, dz_d;

   logic [31:0] abs_a, abs_b;
   logic [32:0] sum33, diff33;
   logic [63:0] sh, prod;

   // |-2^31| wraps to 0x80000000, which is the correct unsigned magnitude
   assign abs_a  = A[31] ? (~A + 32'd1) : A;
   assign abs_b  = B[31] ? (~B + 32'd1) : B;
   assign sum33  = {1'b0, acc_q[63:32]} + {1'b0, dvs_q};
   assign sh     = {acc_q[62:0], 1'b0};
   assign diff33 = {1'b0, sh[63:32]} - {1'b0, dvs_q};
   assign prod   = neg_q ? (~acc_q + 64'd1) : acc_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dz_d    = dz_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               if (Op && (B == 32'd0)) begin
                  dz_d    = 1'b1;
                  done_d  = 1'b1;
                  state_d = FIN;
               end else begin
                  dz_d    = 1'b0;
                  op_d    = Op;
                  neg_d   = A[31] ^ B[31];
                  rneg_d  = A[31];
                  cnt_d   = 5'd0;
                  busy_d  = 1'b1;
                  acc_d   = Op ? {32'd0, abs_a} : {32'd0, abs_b};
                  dvs_d   = Op ? abs_b : abs_a;
                  state_d = Op ? DIV : MULT;
               end
            end
         end
         MULT: begin
            acc_d = acc_q[0] ? {sum33, acc_q[31:1]} : {1'b0, acc_q[63:1]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = FIN;
         end
         DIV: begin
            acc_d = diff33[32] ? sh : {diff33[31:0], sh[31:1], 1'b1};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = FIN;
         end
         FIN: begin
            state_d = IDLE;
            // dz_q here means the divide-by-zero shortcut: Hi/Lo stay untouched
            if (!dz_q) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               if (op_q) begin
                  lo_d = neg_q  ? (~acc_q[31:0]  + 32'd1) : acc_q[31:0];
                  hi_d = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
               end else begin
                  hi_d = prod[63:32];
                  lo_d = prod[31:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         acc_q   <= 64'd0;
         dvs_q   <= 32'd0;
         cnt_q   <= 5'd0;
         op_q    <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign Hi      = hi_q;
   assign Lo      = lo_q;
   assign Busy    = busy_q;
   assign Done    = done_q;
   assign DivZero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: reset/abort, signed mult/div corners,
// divide-by-zero, ignored re-starts and back-to-back issue.
module tb_mult_div_unit;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        Start = 1'b0;
   logic        Op = 1'b0;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic [31:0] Hi, Lo;
   logic        Busy, Done, DivZero;

   int checks = 0;
   int errors = 0;

   mult_div_unit dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
      .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .DivZero(DivZero)
   );

   always #5 Clk = ~Clk;

   // Drives Start across one edge (E0); returns #1 after E0 with operands scrambled.
   task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
      @(negedge Clk);
      Start = 1'b1; Op = op; A = a; B = b;
      @(posedge Clk); #1;
      Start = 1'b0; A = 32'hDEAD_BEEF; B = 32'h1234_5678;
   endtask

   // Counts edges after E0 until Done is seen (bounded); n=61 means timeout.
   task automatic wait_done(output int n, output logic busy_all);
      busy_all = 1'b1;
      n = 61;
      for (int k = 1; k <= 60; k++) begin
         @(posedge Clk); #1;
         if (Done) begin
            n = k;
            break;
         end
         if (!Busy) busy_all = 1'b0;
      end
   endtask

   task automatic test_reset();
      int n; logic ba;
      repeat (2) @(posedge Clk); #1;
      checks++; if (Hi !== 32'd0)  begin errors++; $display("FAIL reset_hi got %h want 0", Hi); end
      checks++; if (Lo !== 32'd0)  begin errors++; $display("FAIL reset_lo got %h want 0", Lo); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
      checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", DivZero); end
      @(negedge Clk); Reset = 1'b1;
      issue(1'b0, 32'd100, 32'd3);
      wait_done(n, ba);
      checks++; if (Lo !== 32'd300) begin errors++; $display("FAIL pre_abort_lo got %h want 12c", Lo); end
      issue(1'b0, 32'd11, 32'd9);
      repeat (10) @(posedge Clk); #1;
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL abort_busy_e10 got %b want 1", Busy); end
      Reset = 1'b0; #1;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", Busy); end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", Done); end
      checks++; if ({Hi, Lo} !== 64'd0) begin errors++; $display("FAIL abort_hilo got %h want 0", {Hi, Lo}); end
      checks++; if (dut.cnt_q !== 5'd0) begin errors++; $display("FAIL abort_cnt got %0d want 0", dut.cnt_q); end
      @(negedge Clk); Reset = 1'b1;
      wait_done(n, ba);
      checks++; if (n !== 61) begin errors++; $display("FAIL abort_no_done got done at edge %0d want none", n); end
      issue(1'b0, 32'd5, 32'd6);
      wait_done(n, ba);
      checks++; if (n !== 33) begin errors++; $display("FAIL mult5x6_latency got %0d want 33", n); end
      checks++; if ({Hi, Lo} !== 64'd30) begin errors++; $display("FAIL mult5x6 got %h want 1e", {Hi, Lo}); end
   endtask

   task automatic test_mult();
      int n; logic ba;
      issue(1'b0, 32'd7, 32'hFFFF_FFFD);
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL mneg_busy_e0 got %b want 1", Busy); end
      wait_done(n, ba);
      checks++; if (n !== 33) begin errors++; $display("FAIL mneg_latency got %0d want 33", n); end
      checks++; if (ba !== 1'b1) begin errors++; $display("FAIL mneg_busy_e1_e32 got %b want 1", ba); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mneg_busy_e33 got %b want 0", Busy); end
      checks++; if (Hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mneg_hi got %h want ffffffff", Hi); end
      checks++; if (Lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mneg_lo got %h want ffffffeb", Lo); end
      @(posedge Clk); #1;
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL mneg_done_width got %b want 0", Done); end
      issue(1'b0, 32'h8000_0000, 32'h8000_0000);
      wait_done(n, ba);
      checks++; if (Hi !== 32'h4000_0000) begin errors++; $display("FAIL mmin_hi got %h want 40000000", Hi); end
      checks++; if (Lo !== 32'h0) begin errors++; $display("FAIL mmin_lo got %h want 0", Lo); end
   endtask

   task automatic test_div();
      int n; logic ba;
      issue(1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_done(n, ba);
      checks++; if (n !== 33) begin errors++; $display("FAIL dneg_latency got %0d want 33", n); end
      checks++; if (Lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL dneg_lo got %h want fffffffd", Lo); end
      checks++; if (Hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dneg_hi got %h want ffffffff", Hi); end
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(n, ba);
      checks++; if (Lo !== 32'h8000_0000) begin errors++; $display("FAIL dmin_lo got %h want 80000000", Lo); end
      checks++; if (Hi !== 32'h0) begin errors++; $display("FAIL dmin_hi got %h want 0", Hi); end
   endtask

   task automatic test_divzero();
      int n; logic ba;
      issue(1'b1, 32'd9, 32'd0);
      checks++; if (Done !== 1'b1) begin errors++; $display("FAIL dz_done got %b want 1", Done); end
      checks++; if (DivZero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", DivZero); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL dz_busy got %b want 0", Busy); end
      @(posedge Clk); #1;
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL dz_done_width got %b want 0", Done); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL dz_busy_e1 got %b want 0", Busy); end
      checks++; if (DivZero !== 1'b1) begin errors++; $display("FAIL dz_sticky got %b want 1", DivZero); end
      checks++; if ({Hi, Lo} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL dz_hilo_kept got %h want 80000000", {Hi, Lo}); end
      issue(1'b1, 32'd20, 32'd3);
      checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL dz_clear got %b want 0", DivZero); end
      wait_done(n, ba);
      checks++; if ({Hi, Lo} !== {32'd2, 32'd6}) begin errors++; $display("FAIL div20_3 got %h want 0000000200000006", {Hi, Lo}); end
   endtask

   task automatic test_back_to_back();
      int n; logic ba;
      issue(1'b0, 32'd1000, 32'hFFFF_FFFD);
      repeat (4) @(posedge Clk);
      @(negedge Clk); Start = 1'b1; Op = 1'b1; A = 32'd100; B = 32'd7;
      @(posedge Clk); #1; Start = 1'b0;
      checks++; if (Busy !== 1'b1 || Done !== 1'b0) begin errors++; $display("FAIL b2b_e5 got busy=%b done=%b want busy=1 done=0", Busy, Done); end
      repeat (27) @(posedge Clk); #1;
      checks++; if (Busy !== 1'b1 || Done !== 1'b0) begin errors++; $display("FAIL b2b_fin got busy=%b done=%b want busy=1 done=0", Busy, Done); end
      @(negedge Clk); Start = 1'b1; Op = 1'b0; A = 32'd2; B = 32'd2;
      @(posedge Clk); #1; Start = 1'b0;
      checks++; if (Done !== 1'b1) begin errors++; $display("FAIL b2b_done_e33 got %b want 1", Done); end
      checks++; if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_F448) begin errors++; $display("FAIL b2b_result got %h want fffffffffffff448", {Hi, Lo}); end
      issue(1'b0, 32'd11, 32'd13);
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_e34 got %b want 1", Busy); end
      wait_done(n, ba);
      checks++; if (n !== 33) begin errors++; $display("FAIL b2b_second_latency got %0d want 33", n); end
      checks++; if ({Hi, Lo} !== 64'd143) begin errors++; $display("FAIL b2b_second got %h want 8f", {Hi, Lo}); end
      wait_done(n, ba);
      checks++; if (n !== 61) begin errors++; $display("FAIL b2b_no_extra_done got done at edge %0d want none", n); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_divzero();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
